// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct constants, ALU function codes and datapath mux encodings.
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_R_EX,
        ST_R_WB,
        ST_MULT_LD,
        ST_I_EX,
        ST_I_WB,
        ST_LS_ADDR,
        ST_LW_MEM,
        ST_LW_WB,
        ST_SW_MEM,
        ST_BR_CMP,
        ST_BR_RES,
        ST_JMP,
        ST_JAL,
        ST_ILLEGAL,
        ST_INTR1,
        ST_INTR2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [4:0] FS_PASS_S = 5'h00;
    localparam logic [4:0] FS_ADD    = 5'h02;
    localparam logic [4:0] FS_SUB    = 5'h04;
    localparam logic [4:0] FS_SLT    = 5'h06;
    localparam logic [4:0] FS_AND    = 5'h08;
    localparam logic [4:0] FS_OR     = 5'h09;
    localparam logic [4:0] FS_MUL    = 5'h1E;

    localparam logic [2:0] Y_HI  = 3'd0;
    localparam logic [2:0] Y_LO  = 3'd1;
    localparam logic [2:0] Y_ALU = 3'd2;
    localparam logic [2:0] Y_DIN = 3'd3;
    localparam logic [2:0] Y_PC  = 3'd4;

    localparam logic [1:0] D_RD = 2'b00;
    localparam logic [1:0] D_RT = 2'b01;
    localparam logic [1:0] D_RA = 2'b10;
    localparam logic [1:0] D_SP = 2'b11;

    localparam logic [1:0] T_RF    = 2'b00;
    localparam logic [1:0] T_IMM   = 2'b01;
    localparam logic [1:0] T_FLAGS = 2'b10;
    localparam logic [1:0] T_PC    = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/mips_funct_decode.sv
// Combinational R-type funct lookup: ALU function plus mult/mflo/unknown tags.
module mips_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [4:0] o_fs,
    output logic       o_is_mult,
    output logic       o_is_mflo,
    output logic       o_bad_funct
);

    always_comb begin
        o_fs        = FS_PASS_S;
        o_is_mult   = 1'b0;
        o_is_mflo   = 1'b0;
        o_bad_funct = 1'b0;
        case (i_funct)
            FN_ADD:  o_fs = FS_ADD;
            FN_SUB:  o_fs = FS_SUB;
            FN_AND:  o_fs = FS_AND;
            FN_OR:   o_fs = FS_OR;
            FN_SLT:  o_fs = FS_SLT;
            FN_MULT: begin
                o_fs      = FS_MUL;
                o_is_mult = 1'b1;
            end
            FN_MFLO: o_is_mflo = 1'b1;
            default: o_bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control_unit.sv
// Multi-cycle MIPS control unit (Moore FSM driving datapath, PC and memories).
// Optional interrupt entry sequence is enabled by defining MCU_INTR_EN.
module mips_mc_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL    = 2'b00,
    parameter logic [1:0] INTR_VECTOR_SEL = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    input  logic        intr,
    output logic [1:0]  pc_sel,
    output logic        pc_ld,
    output logic        ir_ld,
    output logic        im_cs,
    output logic        im_rd,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic        D_En,
    output logic [1:0]  D_sel,
    output logic [1:0]  T_Sel,
    output logic        S_Sel,
    output logic        HILO_ld,
    output logic        FLAG_ld,
    output logic [2:0]  Y_Sel,
    output logic [4:0]  FS,
    output logic        int_ack,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_ostate;
    logic       w_final;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic [4:0] w_fs;
    logic       w_is_mult;
    logic       w_is_mflo;
    logic       w_bad_funct;
    logic       w_unused;

    assign w_unused = ^{N, C, V, IR[25:6]};

    mips_funct_decode u_funct_decode (
        .i_funct     (r_funct),
        .o_fs        (w_fs),
        .o_is_mult   (w_is_mult),
        .o_is_mflo   (w_is_mflo),
        .o_bad_funct (w_bad_funct)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_DECODE) begin
            r_op    <= IR[31:26];
            r_funct <= IR[5:0];
        end
    end

`ifdef MCU_INTR_EN
    logic r_intr_ok;

    // Re-armed only once an instruction has retired since the last entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_intr_ok <= 1'b1;
        end else if (r_state == ST_INTR2) begin
            r_intr_ok <= 1'b0;
        end else if (w_final) begin
            r_intr_ok <= 1'b1;
        end
    end
`else
    logic w_unused_intr;
    assign w_unused_intr = ^{intr, INTR_VECTOR_SEL};
`endif

    always_comb begin
        w_next  = r_state;
        w_final = 1'b0;
        case (r_state)
            ST_RESET:   w_next = ST_FETCH;
            ST_FETCH:   w_next = ST_DECODE;
            ST_DECODE: begin
                case (IR[31:26])
                    OP_RTYPE:        w_next = ST_R_EX;
                    OP_ADDI, OP_ORI: w_next = ST_I_EX;
                    OP_LW, OP_SW:    w_next = ST_LS_ADDR;
                    OP_BEQ, OP_BNE:  w_next = ST_BR_CMP;
                    OP_J:            w_next = ST_JMP;
                    OP_JAL:          w_next = ST_JAL;
                    default:         w_next = ST_ILLEGAL;
                endcase
            end
            ST_R_EX: begin
                if (w_bad_funct) begin
                    w_next = ST_ILLEGAL;
                end else if (w_is_mult) begin
                    w_next = ST_MULT_LD;
                end else begin
                    w_next = ST_R_WB;
                end
            end
            ST_I_EX:    w_next = ST_I_WB;
            ST_LS_ADDR: w_next = (r_op == OP_LW) ? ST_LW_MEM : ST_SW_MEM;
            ST_LW_MEM:  w_next = ST_LW_WB;
            ST_BR_CMP:  w_next = ST_BR_RES;
            ST_R_WB, ST_MULT_LD, ST_I_WB, ST_LW_WB, ST_SW_MEM,
            ST_BR_RES, ST_JMP, ST_JAL: begin
                w_final = 1'b1;
                w_next  = ST_FETCH;
            end
            ST_ILLEGAL: w_next = ST_ILLEGAL;
            ST_INTR1:   w_next = ST_INTR2;
            ST_INTR2:   w_next = ST_FETCH;
            default:    w_next = ST_RESET;
        endcase
`ifdef MCU_INTR_EN
        if (w_final && intr && r_intr_ok) begin
            w_next = ST_INTR1;
        end
`endif
    end

    // The reset cycle itself must not write, so reset forces the RESET word.
    assign w_ostate = reset ? ST_RESET : r_state;

    always_comb begin
        pc_sel  = PC_INC;
        pc_ld   = 1'b0;
        ir_ld   = 1'b0;
        im_cs   = 1'b0;
        im_rd   = 1'b0;
        dm_cs   = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;
        D_En    = 1'b0;
        D_sel   = D_RD;
        T_Sel   = T_RF;
        S_Sel   = 1'b0;
        HILO_ld = 1'b0;
        FLAG_ld = 1'b0;
        Y_Sel   = Y_ALU;
        FS      = FS_PASS_S;
        int_ack = 1'b0;
        illegal = 1'b0;
        case (w_ostate)
            ST_RESET: pc_sel = RESET_PC_SEL;
            ST_FETCH: begin
                im_cs = 1'b1;
                im_rd = 1'b1;
                ir_ld = 1'b1;
                pc_ld = 1'b1;
            end
            ST_R_EX: begin
                FS    = w_fs;
                Y_Sel = w_is_mflo ? Y_LO : Y_ALU;
            end
            ST_MULT_LD: begin
                FS      = FS_MUL;
                HILO_ld = 1'b1;
            end
            ST_R_WB: begin
                D_En  = 1'b1;
                D_sel = D_RD;
                Y_Sel = w_is_mflo ? Y_LO : Y_ALU;
            end
            ST_I_EX: begin
                T_Sel = T_IMM;
                FS    = (r_op == OP_ORI) ? FS_OR : FS_ADD;
            end
            ST_I_WB: begin
                D_En  = 1'b1;
                D_sel = D_RT;
            end
            ST_LS_ADDR: begin
                T_Sel = T_IMM;
                FS    = FS_ADD;
            end
            ST_LW_MEM: begin
                dm_cs = 1'b1;
                dm_rd = 1'b1;
            end
            ST_LW_WB: begin
                D_En  = 1'b1;
                D_sel = D_RT;
                Y_Sel = Y_DIN;
            end
            ST_SW_MEM: begin
                dm_cs = 1'b1;
                dm_wr = 1'b1;
            end
            ST_BR_CMP: FS = FS_SUB;
            ST_BR_RES: begin
                if (((r_op == OP_BEQ) && Z) || ((r_op == OP_BNE) && !Z)) begin
                    pc_ld  = 1'b1;
                    pc_sel = PC_BR;
                end
            end
            ST_JMP: begin
                pc_ld  = 1'b1;
                pc_sel = PC_JMP;
            end
            ST_JAL: begin
                D_En   = 1'b1;
                D_sel  = D_RA;
                Y_Sel  = Y_PC;
                pc_ld  = 1'b1;
                pc_sel = PC_JMP;
            end
            ST_ILLEGAL: illegal = 1'b1;
`ifdef MCU_INTR_EN
            ST_INTR1: begin
                D_En  = 1'b1;
                D_sel = D_RA;
                Y_Sel = Y_PC;
            end
            ST_INTR2: begin
                pc_ld   = 1'b1;
                pc_sel  = INTR_VECTOR_SEL;
                int_ack = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control_unit.sv
// Directed bench for mips_mc_control_unit; each cycle's full control word is
// compared against a hand-written expected word.
module tb_mips_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        N, Z, C, V, intr;
    logic [1:0]  pc_sel;
    logic        pc_ld, ir_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr, D_En;
    logic [1:0]  D_sel, T_Sel;
    logic        S_Sel, HILO_ld, FLAG_ld;
    logic [2:0]  Y_Sel;
    logic [4:0]  FS;
    logic        int_ack, illegal;

    int total = 0;
    int bad   = 0;
    logic [26:0] exp_q[$];
    logic [26:0] w_reset, w_fetch, w_idle, w_ill;

    mips_mc_control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .C(C), .V(V),
        .intr(intr), .pc_sel(pc_sel), .pc_ld(pc_ld), .ir_ld(ir_ld),
        .im_cs(im_cs), .im_rd(im_rd), .dm_cs(dm_cs), .dm_rd(dm_rd),
        .dm_wr(dm_wr), .D_En(D_En), .D_sel(D_sel), .T_Sel(T_Sel),
        .S_Sel(S_Sel), .HILO_ld(HILO_ld), .FLAG_ld(FLAG_ld), .Y_Sel(Y_Sel),
        .FS(FS), .int_ack(int_ack), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] ow();
        return {pc_sel, pc_ld, ir_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr, D_En,
                D_sel, T_Sel, S_Sel, HILO_ld, FLAG_ld, Y_Sel, FS, int_ack, illegal};
    endfunction

    // Expected word; im drives both im_cs and im_rd, S_Sel/FLAG_ld always 0.
    function automatic logic [26:0] mk(input logic [1:0] ps, input logic pl,
                                       input logic il, input logic im,
                                       input logic dc, input logic dr,
                                       input logic dw, input logic de,
                                       input logic [1:0] ds, input logic [1:0] ts,
                                       input logic hl, input logic [2:0] ys,
                                       input logic [4:0] fs, input logic ak,
                                       input logic ill);
        return {ps, pl, il, im, im, dc, dr, dw, de, ds, ts, 1'b0, hl, 1'b0,
                ys, fs, ak, ill};
    endfunction

    task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%07h exp=%07h", tag, got, expv);
        end
    endtask

    task automatic e(input logic [26:0] w);
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle; checks one word per cycle from the queue.
    task automatic run(input string tag, input logic [31:0] ir_v, input logic z_v);
        IR = ir_v;
        Z  = z_v;
        #1;
        foreach (exp_q[i]) begin
            chk($sformatf("%s.c%0d", tag, i + 1), ow(), exp_q[i]);
            tick();
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".hold"}, ow(), w_reset);
        tick();
        reset = 1'b0;
        #1;
        chk({tag, ".rst"}, ow(), w_reset);
        tick();
        chk({tag, ".fetch"}, ow(), w_fetch);
    endtask

    initial begin
        w_reset = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0);
        w_fetch = mk(2'b00, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0);
        w_idle  = w_reset;
        w_ill   = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 1);
        reset = 1'b1; IR = 32'h0; N = 0; Z = 0; C = 0; V = 0; intr = 0;

        // reset held two cycles, then RESET for one cycle, then FETCH
        tick();
        chk("rst.hold1", ow(), w_reset);
        tick();
        chk("rst.hold2", ow(), w_reset);
        reset = 1'b0;
        #1;
        chk("rst.c1", ow(), w_reset);
        tick();
        chk("rst.c2", ow(), w_fetch);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("add", 32'h01095020, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 3'd3, 5'h00, 0, 0));
        run("lw", 32'h8D0A0004, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("sw", 32'hAD0A0004, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("addi", 32'h210A0005, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 3'd2, 5'h09, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("ori", 32'h350A00FF, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h04, 0, 0));
        e(mk(2'b01, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("beq.z1", 32'h11090003, 1'b1);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h04, 0, 0));
        e(w_idle);
        run("beq.z0", 32'h11090003, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h04, 0, 0));
        e(mk(2'b01, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("bne.z0", 32'h15090003, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h04, 0, 0));
        e(w_idle);
        run("bne.z1", 32'h15090003, 1'b1);

        e(w_fetch); e(w_idle);
        e(mk(2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("j", 32'h08000010, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b10, 1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'd4, 5'h00, 0, 0));
        run("jal", 32'h0C000010, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h1E, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 3'd2, 5'h1E, 0, 0));
        run("mult", 32'h01090018, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd1, 5'h00, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd1, 5'h00, 0, 0));
        run("mflo", 32'h00005012, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h06, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("slt", 32'h0109502A, 1'b0);

        intr = 1'b1;
`ifdef MCU_INTR_EN
        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'd4, 5'h00, 0, 0));
        e(mk(2'b11, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 1, 0));
        run("intr.take", 32'h01095020, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("intr.block", 32'h08000010, 1'b0);

        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'd4, 5'h00, 0, 0));
        e(mk(2'b11, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h00, 1, 0));
        run("intr.retake", 32'h01095020, 1'b0);
`else
        e(w_fetch); e(w_idle);
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'd2, 5'h02, 0, 0));
        e(mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        run("intr.ignored", 32'h01095020, 1'b0);
`endif
        intr = 1'b0;
        chk("post.intr.fetch", ow(), w_fetch);

        // reset during R_WB of an add: no write in that cycle
        IR = 32'h01095020;
        tick();
        tick();
        tick();
        chk("abort.rwb", ow(), mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3'd2, 5'h00, 0, 0));
        do_reset("abort");

        e(w_fetch); e(w_idle);
        for (int i = 0; i < 10; i++) e(w_ill);
        run("ill.op", 32'hFC000000, 1'b0);
        chk("ill.op.stay", ow(), w_ill);
        do_reset("ill.op.clr");

        e(w_fetch); e(w_idle); e(w_idle); e(w_ill); e(w_ill);
        run("ill.fn", 32'h0109503F, 1'b0);
        do_reset("ill.fn.clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control_unit.md
Name: mips_mc_control_unit

Overview:
- Multi-cycle control unit for the integer datapath. It is the driving end of the datapath control interface.
- Decodes the instruction register and sequences the FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states.
- Emits, every cycle, the control word consumed by the datapath, PC and memories (D_En, D_sel, T_Sel, S_Sel, HILO_ld, Y_Sel, FS, memory strobes).
- Consumes the datapath N/Z/C/V flags to resolve branches.

Parameters:
- RESET_PC_SEL, 2'b00, pc_sel value used while in RESET.
- INTR_VECTOR_SEL, 2'b11, pc_sel value that loads the interrupt vector (used only with the macro).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents (opcode IR[31:26], funct IR[5:0])
- N, Z, C, V  in  1 each  datapath ALU flags
- intr  in  1  interrupt request, level
- pc_sel  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target, 11 vector
- pc_ld  out  1  load PC
- ir_ld  out  1  load IR
- im_cs, im_rd  out  1 each  instruction memory strobes
- dm_cs, dm_rd, dm_wr  out  1 each  data memory strobes
- D_En  out  1  register file write enable
- D_sel  out  2  destination: 00 rd, 01 rt, 10 $31, 11 $29
- T_Sel  out  2  T mux: 00 RF, 01 DT immediate, 10 flags, 11 PC
- S_Sel  out  1  S mux: 0 RF, 1 ALU_OUT
- HILO_ld  out  1  HI/LO load
- FLAG_ld  out  1  flag restore
- Y_Sel  out  3  0 HI, 1 LO, 2 ALU_OUT, 3 D_in, 4 PC
- FS  out  5  ALU function select
- int_ack  out  1  interrupt acknowledge pulse
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Moore machine. Outputs decode combinationally from a registered state; opcode and funct are captured into internal registers in DECODE.
- Reset:
  - Synchronous: state becomes RESET on the next clk edge.
  - All strobes, enables and illegal are 0; FS = PASS_S; Y_Sel = 2; D_sel = 00; T_Sel = 00; pc_sel = RESET_PC_SEL.
  - RESET lasts 1 cycle, then FETCH.
  - Reset asserted mid-instruction aborts the instruction. No write occurs in the reset cycle.
- FETCH: im_cs = im_rd = 1, ir_ld = 1, pc_ld = 1, pc_sel = 00.
- DECODE: RS/RT are latched by the datapath. The opcode selects the next state:
  - R-type (0x00) -> R_EX
  - addi (0x08) and ori (0x0D) -> I_EX
  - lw (0x23) -> LS_ADDR
  - sw (0x2B) -> LS_ADDR
  - beq (0x04) and bne (0x05) -> BR_CMP
  - j (0x02) -> JMP
  - jal (0x03) -> JAL
  - anything else -> ILLEGAL
- R_EX:
  - FS comes from the funct map: add 0x20->ADD, sub 0x22->SUB, and 0x24->AND, or 0x25->OR, slt 0x2A->SLT, mult 0x18->MUL, mflo 0x12 handled separately.
  - mult: HILO_ld = 1, then back to FETCH (4 cycles total).
  - mflo: goes to R_WB with Y_Sel = 1.
  - Unknown funct: ILLEGAL.
- R_WB: D_En = 1, D_sel = 00, Y_Sel = 2 (1 for mflo) -> FETCH.
- I_EX: T_Sel = 01, FS = ADD or OR. Next state I_WB: D_En = 1, D_sel = 01, Y_Sel = 2.
- LS_ADDR: T_Sel = 01, FS = ADD.
  - lw -> LW_MEM: dm_cs = dm_rd = 1. Then LW_WB: D_En = 1, D_sel = 01, Y_Sel = 3.
  - sw -> SW_MEM: dm_cs = dm_wr = 1.
- BR_CMP: FS = SUB. Next state BR_RES:
  - beq: pc_ld = 1, pc_sel = 01 iff Z = 1.
  - bne: pc_ld = 1, pc_sel = 01 iff Z = 0.
  - Otherwise no pc_ld.
- JMP: pc_ld = 1, pc_sel = 10.
- JAL: D_En = 1, D_sel = 10, Y_Sel = 4, pc_ld = 1, pc_sel = 10.
- Latency in cycles, counted from FETCH:
  - R-type ALU op 4; mult 4
  - addi 4; lw 5; sw 4
  - branch 4; j 3; jal 3
- ILLEGAL: illegal = 1, all enables 0, self-loop until reset.
- Write exclusivity: D_En, dm_wr and HILO_ld are never asserted in the same cycle.

Optional Feature:
- Macro: MCU_INTR_EN.
- With the macro:
  - In the final state of any instruction, if intr = 1, next state is INTR1 instead of FETCH.
  - INTR1: D_En = 1, D_sel = 10, Y_Sel = 4 (PC saved to $31).
  - INTR2: pc_ld = 1, pc_sel = INTR_VECTOR_SEL, int_ack = 1 for exactly 1 cycle, -> FETCH.
  - A new interrupt is accepted only after at least one full instruction has executed.
- Without the macro: intr is ignored and int_ack is tied to 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum
  - opcode and funct constants
  - FS codes: PASS_S 0x00, ADD 0x02, SUB 0x04, SLT 0x06, AND 0x08, OR 0x09, MUL 0x1E
  - Y_Sel, D_sel and T_Sel encodings
- One natural sub-module: mips_funct_decode, a combinational funct -> {FS, is_mult, is_mflo, bad_funct} lookup.

Test Plan:
- Reset held 2 cycles, then released -> cycle 1 in RESET with all enables 0; cycle 2 in FETCH with im_rd = ir_ld = pc_ld = 1.
- IR = 0x01095020 (add $10,$8,$9) -> R_EX FS = 0x02; R_WB D_En = 1, D_sel = 00, Y_Sel = 2; FETCH 4 cycles after the start.
- IR = 0x8D0A0004 (lw) -> dm_rd = 1 in cycle 4, D_En = 1 with Y_Sel = 3 and D_sel = 01 in cycle 5.
- IR = 0x11090003 (beq): with Z = 1, BR_RES gives pc_ld = 1, pc_sel = 01; with Z = 0, pc_ld = 0.
- IR = 0xFC000000 -> illegal = 1 from the cycle after DECODE, stays 1 for 10 cycles, clears on reset.
- Under MCU_INTR_EN: intr = 1 during R_WB -> INTR1 (D_sel = 10, Y_Sel = 4), then INTR2 with int_ack = 1 for one cycle, then FETCH.
